csr_file_m: RTL and testbench

//  Parametrised machine-mode CSR file for the scpu datapath. Replaces the fixed
//  64-bit unit: full Zicsr RW/RS/RC semantics, trap entry and MRET, mtval and

---
 rtl/csr_file_if.sv | 36 +++
 rtl/csr_file_m.sv | 150 +++++++++++++++
 tb/tb_csr_file_m.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// Bus between the scpu pipeline (ID read port, EX write port, trap/retire
// control) and the machine-mode CSR file.
interface csr_file_if #(
    parameter int XLEN = 64
);
    logic [11:0]     csr_rd_addr;
    logic [XLEN-1:0] csr_rd_data;
    logic            csr_illegal;
    logic [1:0]      csr_wr_op;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_wr_src;
    logic            csr_wr_src_zero;
    logic            trap_valid;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret;
    logic            inst_retire;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mepc_out;
    logic            irq_enable;

    // Pipeline side: issues reads, writes and trap/retire events.
    modport master (
        output csr_rd_addr, csr_wr_op, csr_wr_addr, csr_wr_src, csr_wr_src_zero,
               trap_valid, trap_cause, trap_pc, trap_tval, mret, inst_retire,
        input  csr_rd_data, csr_illegal, trap_target, mepc_out, irq_enable
    );

    // CSR file side.
    modport slave (
        input  csr_rd_addr, csr_wr_op, csr_wr_addr, csr_wr_src, csr_wr_src_zero,
               trap_valid, trap_cause, trap_pc, trap_tval, mret, inst_retire,
        output csr_rd_data, csr_illegal, trap_target, mepc_out, irq_enable
    );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: Zicsr RW/RS/RC, trap entry and MRET, mcycle/minstret
// counters and a registered read port that returns the post-edge value of the
// addressed CSR (writes, trap updates and counter steps are all bypassed).
module csr_file_m #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter bit              HAS_COUNTERS = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    csr_file_if.slave   bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    typedef struct packed {
        logic            mie;
        logic            mpie;
        logic [XLEN-1:0] mtvec;
        logic [XLEN-1:0] mscratch;
        logic [XLEN-1:0] mepc;
        logic [XLEN-1:0] mcause;
        logic [XLEN-1:0] mtval;
        logic [XLEN-1:0] mcycle;
        logic [XLEN-1:0] minstret;
    } csr_state_t;

    csr_state_t      st_q, st_nxt;
    logic [XLEN-1:0] rd_data_q;
    logic            illegal_q;
    logic [XLEN-1:0] wr_old, wr_val, tvec_base;
    logic            wr_en;

    // Architectural read value of one CSR as seen by software.
    function automatic logic [XLEN-1:0] csr_view(input csr_state_t s, input logic [11:0] addr);
        logic [XLEN-1:0] v;
        v = '0;
        case (addr)
            A_MSTATUS: begin
                v[3]     = s.mie;
                v[7]     = s.mpie;
                v[12:11] = 2'b11;
            end
            A_MTVEC:               v = s.mtvec;
            A_MSCRATCH:            v = s.mscratch;
            A_MEPC:                v = s.mepc;
            A_MCAUSE:              v = s.mcause;
            A_MTVAL:               v = s.mtval;
            A_MCYCLE, A_CYCLE:     v = s.mcycle;
            A_MINSTRET, A_INSTRET: v = s.minstret;
            default:               v = '0;
        endcase
        return v;
    endfunction

    function automatic logic csr_known(input logic [11:0] addr);
        case (addr)
            A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET, A_MHARTID: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Only direct (0) and vectored (1) modes are kept; reserved modes fall back to direct.
    function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 1'b0, (v[1:0] == 2'b01)};
    endfunction

    // Next-state of every CSR: counters step, then CSR write, then mret, then trap,
    // so later events overwrite only the fields they own.
    always_comb begin
        st_nxt = st_q;
        wr_old = csr_view(st_q, bus.csr_wr_addr);
        wr_val = '0;
        case (bus.csr_wr_op)
            2'b01:   wr_val = bus.csr_wr_src;
            2'b10:   wr_val = wr_old | bus.csr_wr_src;
            2'b11:   wr_val = wr_old & ~bus.csr_wr_src;
            default: wr_val = '0;
        endcase
        wr_en = (bus.csr_wr_op != 2'b00) && !(bus.csr_wr_op[1] && bus.csr_wr_src_zero);

        if (HAS_COUNTERS) begin
            st_nxt.mcycle   = st_q.mcycle + XLEN'(1);
            st_nxt.minstret = st_q.minstret + XLEN'(bus.inst_retire);
        end

        if (wr_en) begin
            case (bus.csr_wr_addr)
                A_MSTATUS: begin
                    st_nxt.mie  = wr_val[3];
                    st_nxt.mpie = wr_val[7];
                end
                A_MTVEC:    st_nxt.mtvec    = legal_mtvec(wr_val);
                A_MSCRATCH: st_nxt.mscratch = wr_val;
                A_MEPC:     st_nxt.mepc     = {wr_val[XLEN-1:2], 2'b00};
                A_MCAUSE:   st_nxt.mcause   = wr_val;
                A_MTVAL:    st_nxt.mtval    = wr_val;
                A_MCYCLE:   if (HAS_COUNTERS) st_nxt.mcycle   = wr_val;
                A_MINSTRET: if (HAS_COUNTERS) st_nxt.minstret = wr_val;
                default: ;
            endcase
        end

        if (bus.mret && !bus.trap_valid) begin
            st_nxt.mie  = st_q.mpie;
            st_nxt.mpie = 1'b1;
        end

        if (bus.trap_valid) begin
            st_nxt.mepc   = {bus.trap_pc[XLEN-1:2], 2'b00};
            st_nxt.mcause = bus.trap_cause;
            st_nxt.mtval  = bus.trap_tval;
            st_nxt.mpie   = st_q.mie;
            st_nxt.mie    = 1'b0;
        end
    end

    // CSR state and read port; the read port samples the next state for bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= '0;
            st_q.mtvec <= MTVEC_RESET;
            rd_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            st_q      <= st_nxt;
            rd_data_q <= csr_view(st_nxt, bus.csr_rd_addr);
            illegal_q <= !csr_known(bus.csr_rd_addr);
        end
    end

    assign tvec_base       = {st_q.mtvec[XLEN-1:2], 2'b00};
    assign bus.trap_target = (st_q.mtvec[1:0] == 2'b01 && bus.trap_cause[XLEN-1])
                             ? tvec_base + {bus.trap_cause[XLEN-3:0], 2'b00}
                             : tvec_base;
    assign bus.csr_rd_data = rd_data_q;
    assign bus.csr_illegal = illegal_q;
    assign bus.mepc_out    = st_q.mepc;
    assign bus.irq_enable  = st_q.mie;
endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an address-keyed CSR model.
module tb_csr_file_m;
    localparam logic [63:0] MTVEC_R = 64'h200;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csr_file_if #(.XLEN(64)) bus ();

    csr_file_m #(.XLEN(64), .MTVEC_RESET(MTVEC_R), .HAS_COUNTERS(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each writable CSR is stored under its address, holding its software-visible value.
    logic [63:0] csr [int];
    logic [63:0] exp_rd;
    logic        exp_ill;
    bit          model_ok = 0;

    function automatic logic m_known(input logic [11:0] a);
        return csr.exists(int'(a)) || a == 12'hC00 || a == 12'hC02 || a == 12'hF14;
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        if (a == 12'hC00) return csr[12'hB00];
        if (a == 12'hC02) return csr[12'hB02];
        if (csr.exists(int'(a))) return csr[int'(a)];
        return 64'd0;
    endfunction

    function automatic logic [63:0] m_target();
        logic [63:0] mt, base;
        mt   = csr[12'h305];
        base = mt & ~64'd3;
        if (mt[1:0] == 2'b01 && bus.trap_cause[63]) return base + (bus.trap_cause << 2);
        return base;
    endfunction

    task automatic model_reset();
        csr.delete();
        csr[12'h300] = 64'h1800;
        csr[12'h305] = MTVEC_R;
        csr[12'h340] = 0; csr[12'h341] = 0; csr[12'h342] = 0; csr[12'h343] = 0;
        csr[12'hB00] = 0; csr[12'hB02] = 0;
        exp_rd   = 0;
        exp_ill  = 0;
        model_ok = 1;
    endtask

    task automatic model_step();
        logic [63:0] nxt [int];
        logic [63:0] old, v, ms;
        int a;
        nxt = csr;
        nxt[12'hB00] = csr[12'hB00] + 64'd1;
        nxt[12'hB02] = csr[12'hB02] + (bus.inst_retire ? 64'd1 : 64'd0);
        a   = int'(bus.csr_wr_addr);
        old = m_read(bus.csr_wr_addr);
        v   = (bus.csr_wr_op == 2'd1) ? bus.csr_wr_src :
              (bus.csr_wr_op == 2'd2) ? (old | bus.csr_wr_src) : (old & ~bus.csr_wr_src);
        if (bus.csr_wr_op != 0 && !(bus.csr_wr_op >= 2 && bus.csr_wr_src_zero) && csr.exists(a)) begin
            if (a == 12'h300)      v = (v & 64'h88) | 64'h1800;
            else if (a == 12'h305) v = (v & ~64'd3) | ((v[1:0] == 2'b01) ? 64'd1 : 64'd0);
            else if (a == 12'h341) v = v & ~64'd3;
            nxt[a] = v;
        end
        ms = csr[12'h300];
        if (bus.mret && !bus.trap_valid)
            nxt[12'h300] = 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
        if (bus.trap_valid) begin
            nxt[12'h341] = bus.trap_pc & ~64'd3;
            nxt[12'h342] = bus.trap_cause;
            nxt[12'h343] = bus.trap_tval;
            nxt[12'h300] = 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
        end
        csr     = nxt;
        exp_rd  = m_read(bus.csr_rd_addr);
        exp_ill = !m_known(bus.csr_rd_addr);
    endtask

    // Model advances on the same edges as the DUT; inputs are stable around posedge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else if (model_ok) model_step();
    end

    // Per-cycle comparison at the falling edge, when all outputs have settled.
    always @(negedge clk) begin
        if (model_ok) begin
            logic [63:0] ms;
            ms = csr[12'h300];
            check("rd_data",     bus.csr_rd_data, exp_rd);
            check("illegal",     {63'd0, bus.csr_illegal}, {63'd0, exp_ill});
            check("trap_target", bus.trap_target, m_target());
            check("mepc_out",    bus.mepc_out, csr[12'h341]);
            check("irq_enable",  {63'd0, bus.irq_enable}, {63'd0, ms[3]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.csr_wr_op       = 2'b00;
        bus.csr_wr_addr     = 12'h0;
        bus.csr_wr_src      = 64'd0;
        bus.csr_wr_src_zero = 1'b0;
        bus.trap_valid      = 1'b0;
        bus.trap_cause      = 64'd0;
        bus.trap_pc         = 64'd0;
        bus.trap_tval       = 64'd0;
        bus.mret            = 1'b0;
        bus.inst_retire     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] src,
                      input logic z, input logic [11:0] ra);
        bus.csr_wr_op       = op;
        bus.csr_wr_addr     = a;
        bus.csr_wr_src      = src;
        bus.csr_wr_src_zero = z;
        bus.csr_rd_addr     = ra;
        cyc();
        bus.csr_wr_op       = 2'b00;
    endtask

    task automatic rd(input logic [11:0] ra);
        bus.csr_rd_addr = ra;
        cyc();
    endtask

    logic [11:0] alist [13];

    initial begin
        alist = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00,
                  12'hB02, 12'hC00, 12'hC02, 12'hF14, 12'h7C0, 12'h123};
        rst_n = 1'b0;
        idle();
        bus.csr_rd_addr = 12'hB00;
        repeat (3) cyc();
        check("reset_rd_data", bus.csr_rd_data, 64'd0);
        check("reset_illegal", {63'd0, bus.csr_illegal}, 64'd0);
        rst_n = 1'b1;
        cyc();
        check("first_mcycle", bus.csr_rd_data, 64'd1);
        rd(12'h305); check("mtvec_reset", bus.csr_rd_data, MTVEC_R);
        rd(12'h340); check("mscratch_reset", bus.csr_rd_data, 64'd0);
        rd(12'h300); check("mstatus_reset", bus.csr_rd_data, 64'h1800);

        wr(2'd1, 12'h340, 64'hA5, 1'b0, 12'h340); check("rw_a5", bus.csr_rd_data, 64'hA5);
        wr(2'd2, 12'h340, 64'h0F, 1'b0, 12'h340); check("rs_0f", bus.csr_rd_data, 64'hAF);
        wr(2'd3, 12'h340, 64'hA0, 1'b0, 12'h340); check("rc_a0", bus.csr_rd_data, 64'h0F);
        wr(2'd2, 12'h340, 64'hF0, 1'b1, 12'h340); check("rs_zero", bus.csr_rd_data, 64'h0F);
        wr(2'd1, 12'h340, 64'h0,  1'b1, 12'h340); check("rw_zero", bus.csr_rd_data, 64'h0);
        wr(2'd1, 12'h305, 64'h1000, 1'b0, 12'h305); check("bypass", bus.csr_rd_data, 64'h1000);

        wr(2'd2, 12'h300, 64'h8, 1'b0, 12'h300);
        check("mie_set", bus.csr_rd_data, 64'h1808);
        check("irq_on", {63'd0, bus.irq_enable}, 64'd1);
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h80; bus.trap_cause = 64'd11;
        bus.trap_tval = 64'h33; bus.csr_rd_addr = 12'h341;
        #1 check("trap_direct", bus.trap_target, 64'h1000);
        cyc();
        idle();
        check("trap_mepc_rd", bus.csr_rd_data, 64'h80);
        check("trap_mepc_out", bus.mepc_out, 64'h80);
        check("trap_irq_off", {63'd0, bus.irq_enable}, 64'd0);
        rd(12'h342); check("trap_mcause", bus.csr_rd_data, 64'd11);
        rd(12'h300); check("trap_mstatus", bus.csr_rd_data, 64'h1880);
        bus.mret = 1'b1;
        rd(12'h300);
        bus.mret = 1'b0;
        check("mret_mstatus", bus.csr_rd_data, 64'h1888);
        check("mret_irq", {63'd0, bus.irq_enable}, 64'd1);

        wr(2'd1, 12'h305, 64'h2002, 1'b0, 12'h305); check("mtvec_mode2", bus.csr_rd_data, 64'h2000);
        wr(2'd1, 12'h305, 64'h1001, 1'b0, 12'h305); check("mtvec_vec", bus.csr_rd_data, 64'h1001);
        bus.trap_cause = {1'b1, 63'd7};
        #1 check("vec_target", bus.trap_target, 64'h101C);
        bus.trap_cause = 64'd7;
        #1 check("vec_exc_target", bus.trap_target, 64'h1000);
        bus.trap_valid = 1'b1; bus.trap_pc = 64'h120; bus.trap_cause = {1'b1, 63'd3};
        wr(2'd1, 12'h341, 64'h44, 1'b0, 12'h341);
        idle();
        check("trap_vs_write", bus.csr_rd_data, 64'h120);

        wr(2'd1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 12'hB00);
        check("mcycle_ones", bus.csr_rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(12'hB00); check("mcycle_wrap", bus.csr_rd_data, 64'd0);
        rd(12'h7C0);
        check("illegal_data", bus.csr_rd_data, 64'd0);
        check("illegal_flag", {63'd0, bus.csr_illegal}, 64'd1);
        rd(12'hF14);
        check("mhartid", bus.csr_rd_data, 64'd0);
        check("mhartid_legal", {63'd0, bus.csr_illegal}, 64'd0);

        for (int i = 0; i < 800; i++) begin
            logic [63:0] src;
            if (i == 400) begin
                rst_n = 1'b0;
                cyc(); cyc();
                rst_n = 1'b1;
            end
            case ($urandom_range(0, 3))
                0:       src = 64'd0;
                1:       src = 64'($urandom_range(0, 255));
                default: src = {$urandom, $urandom};
            endcase
            bus.csr_wr_op       = 2'($urandom_range(0, 3));
            bus.csr_wr_addr     = alist[$urandom_range(0, 12)];
            bus.csr_wr_src      = src;
            bus.csr_wr_src_zero = (src == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                bus.csr_wr_op   = 2'd1;
                bus.csr_wr_addr = ($urandom_range(0, 1) == 0) ? 12'hB00 : 12'hB02;
                bus.csr_wr_src  = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 2));
            end
            bus.csr_rd_addr = alist[$urandom_range(0, 12)];
            bus.trap_valid  = ($urandom_range(0, 9) == 0);
            bus.trap_cause  = {$urandom, $urandom};
            bus.trap_pc     = {$urandom, $urandom};
            bus.trap_tval   = {$urandom, $urandom};
            bus.mret        = ($urandom_range(0, 7) == 0);
            bus.inst_retire = $urandom_range(0, 1) == 1;
            cyc();
        end
        idle();
        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
